multicycle_controller: RTL

- Moore-style FSM that sequences a shared-ALU, single-memory multicycle RV32I datapath through fetch, decode, execute, memory and writeback steps.
- Drives every datapath select and enable, and performs a req/ready handshake with the unified instruction/data memory.
- Its immediate-select and ALU-op encodings match the main decoder's, so the ALU decoder and immediate extender are reused unchanged.

---
 rtl/multicycle_controller.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a shared-ALU, single-memory multicycle RV32I datapath.
// Optional: define MC_ILLEGAL_OP_TRAP_EN to send unlisted opcodes to a sticky TRAP state.
module multicycle_controller #(
   parameter int unsigned OP_W    = 7,
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    op,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               branch,
   output logic               adr_src,
   output logic               mem_req,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [2:0]         imm_src,
   output logic [STATE_W-1:0] state_o,
   output logic               trap
);

   localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
   localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
   localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(7'b0110011);
   localparam logic [OP_W-1:0] OP_ITYPE  = OP_W'(7'b0010011);
   localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);
   localparam logic [OP_W-1:0] OP_JAL    = OP_W'(7'b1101111);
   localparam logic [OP_W-1:0] OP_JALR   = OP_W'(7'b1100111);
   localparam logic [OP_W-1:0] OP_LUI    = OP_W'(7'b0110111);
   localparam logic [OP_W-1:0] OP_AUIPC  = OP_W'(7'b0010111);

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_BR   = 2'b01;
   localparam logic [1:0] ALUOP_FN   = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_START    = STATE_W'(0),
      S_FETCH    = STATE_W'(1),
      S_DECODE   = STATE_W'(2),
      S_MEMADR   = STATE_W'(3),
      S_MEMREAD  = STATE_W'(4),
      S_MEMWB    = STATE_W'(5),
      S_MEMWRITE = STATE_W'(6),
      S_EXECR    = STATE_W'(7),
      S_EXECI    = STATE_W'(8),
      S_ALUWB    = STATE_W'(9),
      S_BRANCH   = STATE_W'(10),
      S_JAL      = STATE_W'(11),
      S_JALR     = STATE_W'(12),
      S_UPPER    = STATE_W'(13)
`ifdef MC_ILLEGAL_OP_TRAP_EN
      , S_TRAP   = STATE_W'(14)
`endif
   } state_e;

   state_e     state_q;
   state_e     state_d;

   logic       jal_pc_q;
   logic       jal_pc_d;
   logic       branch_d;
   logic       adr_src_d;
   logic       mem_req_d;
   logic       mem_write_d;
   logic       reg_write_d;
   logic [1:0] result_src_d;
   logic [1:0] alu_src_a_d;
   logic [1:0] alu_src_b_d;
   logic [1:0] alu_op_d;
   logic       fetch_ack;

   // Next-state: op only consulted in DECODE and MEMADR; memory states hold until mem_ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_START:    state_d = S_FETCH;
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI, OP_AUIPC:  state_d = S_UPPER;
`ifdef MC_ILLEGAL_OP_TRAP_EN
               default:           state_d = S_TRAP;
`else
               default:           state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JALR:     state_d = S_JAL;
         S_JAL:      state_d = S_ALUWB;
         S_UPPER:    state_d = S_ALUWB;
`ifdef MC_ILLEGAL_OP_TRAP_EN
         S_TRAP:     state_d = S_TRAP;
`endif
         default:    state_d = S_START;
      endcase
   end

   // Moore outputs decoded from the state being entered, so they register alongside it.
   always_comb begin
      jal_pc_d     = 1'b0;
      branch_d     = 1'b0;
      adr_src_d    = 1'b0;
      mem_req_d    = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      result_src_d = RES_ALUOUT;
      alu_src_a_d  = SRCA_PC;
      alu_src_b_d  = SRCB_RS2;
      alu_op_d     = ALUOP_ADD;
      case (state_d)
         S_FETCH: begin
            mem_req_d    = 1'b1;
            alu_src_a_d  = SRCA_PC;
            alu_src_b_d  = SRCB_FOUR;
            result_src_d = RES_ALU;
         end
         S_DECODE: begin
            alu_src_a_d = SRCA_OLDPC;
            alu_src_b_d = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a_d = SRCA_RS1;
            alu_src_b_d = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req_d = 1'b1;
            adr_src_d = 1'b1;
         end
         S_MEMWB: begin
            result_src_d = RES_RDATA;
            reg_write_d  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req_d   = 1'b1;
            mem_write_d = 1'b1;
            adr_src_d   = 1'b1;
         end
         S_EXECR: begin
            alu_src_a_d = SRCA_RS1;
            alu_src_b_d = SRCB_RS2;
            alu_op_d    = ALUOP_FN;
         end
         S_EXECI: begin
            alu_src_a_d = SRCA_RS1;
            alu_src_b_d = SRCB_IMM;
            alu_op_d    = ALUOP_FN;
         end
         S_ALUWB: begin
            result_src_d = RES_ALUOUT;
            reg_write_d  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_d  = SRCA_RS1;
            alu_src_b_d  = SRCB_RS2;
            alu_op_d     = ALUOP_BR;
            result_src_d = RES_ALUOUT;
            branch_d     = 1'b1;
         end
         S_JALR: begin
            alu_src_a_d = SRCA_RS1;
            alu_src_b_d = SRCB_IMM;
         end
         S_JAL: begin
            jal_pc_d     = 1'b1;
            result_src_d = RES_ALUOUT;
            alu_src_a_d  = SRCA_OLDPC;
            alu_src_b_d  = SRCB_FOUR;
         end
         S_UPPER: begin
            alu_src_a_d = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            alu_src_b_d = SRCB_IMM;
         end
         default: ;
      endcase
   end

   // State and registered outputs; reset clears them asynchronously, dropping any mem_req.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_START;
         jal_pc_q   <= 1'b0;
         branch     <= 1'b0;
         adr_src    <= 1'b0;
         mem_req    <= 1'b0;
         mem_write  <= 1'b0;
         reg_write  <= 1'b0;
         result_src <= RES_ALUOUT;
         alu_src_a  <= SRCA_PC;
         alu_src_b  <= SRCB_RS2;
         alu_op     <= ALUOP_ADD;
      end else begin
         state_q    <= state_d;
         jal_pc_q   <= jal_pc_d;
         branch     <= branch_d;
         adr_src    <= adr_src_d;
         mem_req    <= mem_req_d;
         mem_write  <= mem_write_d;
         reg_write  <= reg_write_d;
         result_src <= result_src_d;
         alu_src_a  <= alu_src_a_d;
         alu_src_b  <= alu_src_b_d;
         alu_op     <= alu_op_d;
      end
   end

`ifdef MC_ILLEGAL_OP_TRAP_EN
   // Sticky trap flag, only cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trap <= 1'b0;
      else        trap <= (state_d == S_TRAP);
   end
`else
   assign trap = 1'b0;
`endif

   // Fetch completes in the cycle the memory answers: latch IR and advance PC together.
   assign fetch_ack = (state_q == S_FETCH) && mem_ready;
   assign ir_write  = fetch_ack;
   assign pc_write  = fetch_ack | jal_pc_q;
   assign state_o   = state_q;

   // Immediate format select, shared encoding with the single-cycle main decoder.
   always_comb begin
      imm_src = 3'b000;
      case (op)
         OP_LOAD, OP_ITYPE, OP_JALR: imm_src = 3'b001;
         OP_STORE:                   imm_src = 3'b010;
         OP_BRANCH:                  imm_src = 3'b011;
         OP_LUI, OP_AUIPC:           imm_src = 3'b100;
         OP_JAL:                     imm_src = 3'b101;
         default:                    imm_src = 3'b000;
      endcase
   end

endmodule
